pool_unit_mc: RTL and testbench
===============================

Name: pool_unit_mc

Overview:
- Multi-channel, parametrised pooling engine on signed fixed-point data.
- Processes CH channel lanes in parallel over a run-time window of op_num input beats, computing either max pooling or average pooling.
- Average pooling uses a caller-supplied reciprocal multiply.
- Sits between the feature-map read path and the output write-back path; started by the command controller.

Parameters:
- DATA_W, 16, bits per channel sample (signed two's complement).
- CH, 4, number of parallel channel lanes.
- CNT_W, 16, width of the window beat counter; max window is 2^CNT_W-1 beats.
- RECIP_W, 16, width of the unsigned reciprocal (Q0.RECIP_W fraction).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pool_ready  in  1  start pulse; sampled only in IDLE.
- mode  in  1  0 = max pool, 1 = average pool; latched on start.
- op_num  in  CNT_W  beats in the window; latched on start.
- recip  in  RECIP_W  1/op_num in Q0.RECIP_W; latched on start; used only in average mode.
- data  in  CH*DATA_W  input beat; lane k occupies bits [k*DATA_W +: DATA_W].
- data_valid  in  1  input beat valid.
- data_ready  out  1  engine accepts a beat this cycle.
- result  out  CH*DATA_W  pooled result per lane, same packing as data.
- pool_valid  out  1  result valid; held until accepted.
- result_ready  in  1  downstream accepts result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: data_ready=0, pool_valid=0, busy=0, result=0, state=IDLE, counters and accumulators 0. Reset mid-operation aborts the window; no partial result is produced.
- States:
  - IDLE. On pool_ready: latch mode/op_num/recip, clear count and accumulators. If op_num==0, go to DONE with result=0; otherwise go to ACC.
  - ACC. data_ready=1. A beat is accepted when data_valid && data_ready; each accepted beat increments count. After the beat making count==op_num, go to SCALE in average mode or DONE in max mode. data_ready drops the cycle after the last beat, so no extra beat is accepted.
  - SCALE. One cycle. Per lane: prod = acc * recip (signed × unsigned), shifted arithmetically right by RECIP_W. The product saturates to the DATA_W signed range and is registered into result. Then go to DONE.
  - DONE. pool_valid=1, result stable. When result_ready: pool_valid falls the next cycle, go to IDLE.
- Max mode:
  - First accepted beat loads each lane's running max directly; later beats replace a lane when data > max (signed compare).
  - On ties the stored value is kept.
  - result = max, registered on entry to DONE.
- Average mode:
  - Accumulator width is DATA_W+CNT_W per lane; it cannot overflow for any legal op_num.
  - A recip that does not match op_num is not checked; the output is simply acc*recip scaled.
- pool_ready while busy is ignored.
- Stalls in ACC (data_valid=0) are allowed indefinitely; state and count are held.
- Latency:
  - Max mode: last beat accepted at cycle t → pool_valid at t+1.
  - Average mode: t+2.
  - Back-to-back windows: pool_ready is accepted the cycle after the DONE→IDLE transition.
- Each lane is fully independent; no cross-lane arithmetic.

Optional Feature:
- Macro POOL_RELU_EN.
- When defined: any negative lane value is clamped to 0 when it is registered into result, in both modes, after saturation.
- When undefined: result carries signed values unchanged.
- The interface is identical in both builds.

Test Plan:
- Max, CH=4, op_num=3, beats {lane0: 5,-2,7}, {lane1: -8,-3,-9}, {lane2: 0,0,0}, {lane3: 32767,1,-32768} → result lanes 7, -3, 0, 32767; pool_valid one cycle after third beat.
- Average, op_num=4, recip=16'h4000, lane0 beats 10,20,30,40 → lane0 result 25 (100*0x4000>>16); pool_valid two cycles after last beat.
- Average saturation, op_num=2, recip=16'hFFFF, lane0 beats 32767,32767 → result 32767 (saturated). Lane1 beats -32768,-32768 → -32768.
- op_num=0 start → DONE directly; pool_valid=1 with all lanes 0 and data_ready never asserted. Second check: pool_ready while busy has no effect.
- Stall/backpressure: data_valid toggling every other cycle; result_ready held low 5 cycles → result and pool_valid stable throughout; assert result_ready → IDLE, busy=0.
- POOL_RELU_EN build: max mode, lane beats -4,-1 → result 0; reset asserted mid-ACC → all outputs return to reset values next cycle.

Source files
------------

// File: rtl/pool_unit_mc.sv
// pool_unit_mc: multi-channel max/average pooling engine on signed fixed-point lanes.
// CH lanes are processed in parallel over a window of op_num input beats.
// Average mode multiplies the lane sum by a caller-supplied Q0.RECIP_W reciprocal.
// Optional build macro POOL_RELU_EN clamps negative lane results to zero.
module pool_unit_mc #(
    parameter int DATA_W  = 16,
    parameter int CH      = 4,
    parameter int CNT_W   = 16,
    parameter int RECIP_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pool_ready,
    input  logic                   mode,
    input  logic [CNT_W-1:0]       op_num,
    input  logic [RECIP_W-1:0]     recip,
    input  logic [CH*DATA_W-1:0]   data,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic [CH*DATA_W-1:0]   result,
    output logic                   pool_valid,
    input  logic                   result_ready,
    output logic                   busy
);

    localparam int ACC_W  = DATA_W + CNT_W;
    localparam int PROD_W = ACC_W + RECIP_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                    state;
    logic                      mode_q;
    logic [CNT_W-1:0]          op_num_q;
    logic [RECIP_W-1:0]        recip_q;
    logic [CNT_W-1:0]          count;
    logic [CNT_W-1:0]          count_nxt;
    logic                      beat_accept;

    logic signed [DATA_W-1:0]  lane_in  [CH];
    logic signed [DATA_W-1:0]  max_q    [CH];
    logic signed [DATA_W-1:0]  max_nxt  [CH];
    logic signed [ACC_W-1:0]   acc_q    [CH];
    logic signed [ACC_W-1:0]   acc_nxt  [CH];
    logic signed [PROD_W-1:0]  prod     [CH];
    logic signed [PROD_W-1:0]  shifted  [CH];
    logic [CH*DATA_W-1:0]      max_packed;
    logic [CH*DATA_W-1:0]      scaled_packed;

    // Clamp a scaled product into the signed DATA_W range.
    function automatic logic [DATA_W-1:0] saturate(input logic signed [PROD_W-1:0] v);
        logic [PROD_W-DATA_W:0] top;
        top = v[PROD_W-1:DATA_W-1];
        if ((&top) || !(|top))
            return v[DATA_W-1:0];
        else if (v[PROD_W-1])
            return {1'b1, {(DATA_W-1){1'b0}}};
        else
            return {1'b0, {(DATA_W-1){1'b1}}};
    endfunction

`ifdef POOL_RELU_EN
    // Negative lane values become zero on their way into result.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? '0 : v;
    endfunction
`else
    // Lane values pass through unchanged.
    function automatic logic [DATA_W-1:0] relu(input logic [DATA_W-1:0] v);
        return v;
    endfunction
`endif

    assign beat_accept = data_valid && data_ready;
    assign count_nxt   = count + CNT_W'(1);

    // Per-lane next running max and running sum for the beat on the input.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            lane_in[k] = data[k*DATA_W +: DATA_W];
            if (count == '0)
                max_nxt[k] = lane_in[k];
            else if (lane_in[k] > max_q[k])
                max_nxt[k] = lane_in[k];
            else
                max_nxt[k] = max_q[k];
            acc_nxt[k] = acc_q[k] + {{CNT_W{lane_in[k][DATA_W-1]}}, lane_in[k]};
        end
    end

    // Per-lane reciprocal multiply, arithmetic shift and saturation.
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            prod[k]    = {{(PROD_W-ACC_W){acc_q[k][ACC_W-1]}}, acc_q[k]}
                       * {{(PROD_W-RECIP_W){1'b0}}, recip_q};
            shifted[k] = prod[k] >>> RECIP_W;
        end
    end

    // Pack the candidate results for both modes into the output lane layout.
    always_comb begin
        max_packed    = '0;
        scaled_packed = '0;
        for (int k = 0; k < CH; k++) begin
            max_packed[k*DATA_W +: DATA_W]    = relu(max_nxt[k]);
            scaled_packed[k*DATA_W +: DATA_W] = relu(saturate(shifted[k]));
        end
    end

    // Control FSM with registered handshake outputs, lane state and result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            mode_q     <= 1'b0;
            op_num_q   <= '0;
            recip_q    <= '0;
            count      <= '0;
            data_ready <= 1'b0;
            pool_valid <= 1'b0;
            busy       <= 1'b0;
            result     <= '0;
            for (int k = 0; k < CH; k++) begin
                acc_q[k] <= '0;
                max_q[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pool_ready) begin
                        mode_q   <= mode;
                        op_num_q <= op_num;
                        recip_q  <= recip;
                        count    <= '0;
                        busy     <= 1'b1;
                        for (int k = 0; k < CH; k++) begin
                            acc_q[k] <= '0;
                            max_q[k] <= '0;
                        end
                        if (op_num == '0) begin
                            result     <= '0;
                            pool_valid <= 1'b1;
                            state      <= DONE;
                        end else begin
                            data_ready <= 1'b1;
                            state      <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (beat_accept) begin
                        count <= count_nxt;
                        for (int k = 0; k < CH; k++) begin
                            max_q[k] <= max_nxt[k];
                            acc_q[k] <= acc_nxt[k];
                        end
                        if (count_nxt == op_num_q) begin
                            data_ready <= 1'b0;
                            if (mode_q) begin
                                state <= SCALE;
                            end else begin
                                result     <= max_packed;
                                pool_valid <= 1'b1;
                                state      <= DONE;
                            end
                        end
                    end
                end
                SCALE: begin
                    result     <= scaled_packed;
                    pool_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (result_ready) begin
                        pool_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pool_unit_mc.sv
// tb_pool_unit_mc: directed self-checking bench for pool_unit_mc (default parameters).
// Expected lane values are hand-computed; under POOL_RELU_EN they pass through a local clamp.
module tb_pool_unit_mc;

    logic        clk;
    logic        rst;
    logic        pool_ready;
    logic        mode;
    logic [15:0] op_num;
    logic [15:0] recip;
    logic [63:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [63:0] result;
    logic        pool_valid;
    logic        result_ready;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

    pool_unit_mc #(
        .DATA_W(16), .CH(4), .CNT_W(16), .RECIP_W(16)
    ) dut (
        .clk(clk), .rst(rst), .pool_ready(pool_ready), .mode(mode),
        .op_num(op_num), .recip(recip), .data(data), .data_valid(data_valid),
        .data_ready(data_ready), .result(result), .pool_valid(pool_valid),
        .result_ready(result_ready), .busy(busy)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] pack4(input logic signed [15:0] a, input logic signed [15:0] b,
                                          input logic signed [15:0] c, input logic signed [15:0] d);
        return {d, c, b, a};
    endfunction

    function automatic logic [15:0] rl(input logic signed [15:0] v);
`ifdef POOL_RELU_EN
        return (v < 0) ? 16'd0 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [63:0] expect4(input logic signed [15:0] a, input logic signed [15:0] b,
                                            input logic signed [15:0] c, input logic signed [15:0] d);
        return {rl(d), rl(c), rl(b), rl(a)};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startWindow(input logic m, input logic [15:0] n, input logic [15:0] r);
        pool_ready = 1'b1;
        mode       = m;
        op_num     = n;
        recip      = r;
        tick();
        pool_ready = 1'b0;
    endtask

    task automatic applyStimulus(input logic [63:0] beat);
        data       = beat;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
    endtask

    task automatic releaseResult();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        checkOutput("release_valid", {63'd0, pool_valid}, 64'd0);
        checkOutput("release_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; pool_ready = 1'b0; mode = 1'b0; op_num = '0; recip = '0;
        data = '0; data_valid = 1'b0; result_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        checkOutput("reset_ready", {63'd0, data_ready}, 64'd0);
        checkOutput("reset_valid", {63'd0, pool_valid}, 64'd0);
        checkOutput("reset_busy", {63'd0, busy}, 64'd0);
        checkOutput("reset_result", result, 64'd0);

        // Max pool, three beats.
        startWindow(1'b0, 16'd3, 16'd0);
        checkOutput("max_busy", {63'd0, busy}, 64'd1);
        checkOutput("max_ready", {63'd0, data_ready}, 64'd1);
        applyStimulus(pack4(5, -8, 0, 32767));
        applyStimulus(pack4(-2, -3, 0, 1));
        checkOutput("max_not_yet", {63'd0, pool_valid}, 64'd0);
        applyStimulus(pack4(7, -9, 0, -32768));
        checkOutput("max_valid", {63'd0, pool_valid}, 64'd1);
        checkOutput("max_ready_drop", {63'd0, data_ready}, 64'd0);
        checkOutput("max_result", result, expect4(7, -3, 0, 32767));
        releaseResult();

        // Average pool, four beats, recip = 1/4.
        startWindow(1'b1, 16'd4, 16'h4000);
        applyStimulus(pack4(10, -4, 0, 1));
        applyStimulus(pack4(20, -4, 0, 2));
        applyStimulus(pack4(30, -4, 0, 3));
        applyStimulus(pack4(40, -4, 0, 5));
        checkOutput("avg_scale_cycle", {63'd0, pool_valid}, 64'd0);
        checkOutput("avg_ready_drop", {63'd0, data_ready}, 64'd0);
        tick();
        checkOutput("avg_valid", {63'd0, pool_valid}, 64'd1);
        checkOutput("avg_result", result, expect4(25, -4, 0, 2));
        releaseResult();

        // Average saturation at both ends of the range.
        startWindow(1'b1, 16'd2, 16'hFFFF);
        applyStimulus(pack4(32767, -32768, 0, 100));
        applyStimulus(pack4(32767, -32768, 0, 100));
        tick();
        checkOutput("sat_valid", {63'd0, pool_valid}, 64'd1);
        checkOutput("sat_result", result, expect4(32767, -32768, 0, 199));
        releaseResult();

        // Empty window goes straight to DONE with a zero result.
        startWindow(1'b0, 16'd0, 16'd0);
        checkOutput("zero_valid", {63'd0, pool_valid}, 64'd1);
        checkOutput("zero_ready", {63'd0, data_ready}, 64'd0);
        checkOutput("zero_result", result, 64'd0);
        startWindow(1'b0, 16'd3, 16'd0);
        checkOutput("busy_ignore_valid", {63'd0, pool_valid}, 64'd1);
        checkOutput("busy_ignore_ready", {63'd0, data_ready}, 64'd0);
        releaseResult();

        // Stalled input and held-off result acceptance.
        startWindow(1'b0, 16'd4, 16'd0);
        for (int i = 0; i < 4; i++) begin
            logic [63:0] beats [4];
            beats[0] = pack4(3, -5, 100, -32768);
            beats[1] = pack4(9, -6, 200, -32768);
            beats[2] = pack4(-1, -7, 150, -32768);
            beats[3] = pack4(9, -8, -300, -32768);
            data = beats[i] ^ 64'hFFFF_FFFF_FFFF_FFFF;
            tick();
            checkOutput("stall_ready", {63'd0, data_ready}, 64'd1);
            checkOutput("stall_valid", {63'd0, pool_valid}, 64'd0);
            applyStimulus(beats[i]);
        end
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_valid", {63'd0, pool_valid}, 64'd1);
            checkOutput("hold_result", result, expect4(9, -5, 200, -32768));
            tick();
        end
        releaseResult();

        // Two negative beats; clamped to zero only in the ReLU build.
        startWindow(1'b0, 16'd2, 16'd0);
        applyStimulus(pack4(-4, -4, -4, -4));
        applyStimulus(pack4(-1, -1, -1, -4));
        checkOutput("neg_result", result, expect4(-1, -1, -1, -4));
        releaseResult();

        // Reset in the middle of a window aborts it.
        startWindow(1'b1, 16'd3, 16'h5555);
        applyStimulus(pack4(11, 22, 33, 44));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("abort_ready", {63'd0, data_ready}, 64'd0);
        checkOutput("abort_valid", {63'd0, pool_valid}, 64'd0);
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_result", result, 64'd0);
        tick();
        checkOutput("abort_stays_idle", {63'd0, pool_valid}, 64'd0);

        // A fresh single-beat window works after the abort.
        startWindow(1'b0, 16'd1, 16'd0);
        applyStimulus(pack4(1, 2, 3, 4));
        checkOutput("after_abort_valid", {63'd0, pool_valid}, 64'd1);
        checkOutput("after_abort_result", result, expect4(1, 2, 3, 4));
        releaseResult();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
